// File: rtl/afe_spi_capture.sv
// afe_spi_capture: oversampled AFE SPI lane receiver with show-ahead word FIFO
module afe_spi_capture #(
  parameter int WORD_WIDTH = 24,
  parameter int FIFO_AW = 3
) (
  input  logic                  sysClk,
  input  logic                  sysReset_n,
  input  logic                  spiClk,
  input  logic                  spiSdi,
  input  logic                  spiLe,
  input  logic                  readStrobe,
  input  logic                  clearStatus,
  output logic                  dataValid,
  output logic [WORD_WIDTH-1:0] dataOut,
  output logic [FIFO_AW:0]      fifoCount,
  output logic [5:0]            lastBitCount,
  output logic                  overflow,
  output logic                  lengthError
);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [2:0] s1_q, s2_q, h_q;
  logic clk_rise, le_rise, le_fall, sdi;
  logic start, commit, good, full, pop, push, shift_en;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [5:0] bit_cnt_q, bit_cnt_d, last_cnt_q, last_cnt_d;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic ovf_q, ovf_d, len_q, len_d;
  assign clk_rise = s2_q[0] & ~h_q[0];
  assign sdi = s2_q[1];
  assign le_rise = s2_q[2] & ~h_q[2];
  assign le_fall = ~s2_q[2] & h_q[2];
  assign count = wptr_q - rptr_q;
  // Two-flop synchronizers plus one history stage for {le, sdi, clk}
  always_ff @(posedge sysClk or negedge sysReset_n)
    if (!sysReset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      h_q <= '0;
    end else begin
      s1_q <= {spiLe, spiSdi, spiClk};
      s2_q <= s1_q;
      h_q <= s2_q;
    end
  // Frame state register
  always_ff @(posedge sysClk or negedge sysReset_n)
    if (!sysReset_n) state_q <= IDLE;
    else state_q <= state_d;
  // LE falling edge opens a frame, LE rising edge closes it
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && le_fall) state_d = SHIFT;
    else if (state_q == SHIFT && le_rise) state_d = IDLE;
  end
  // Frame control strobes; an LE rise suppresses a coincident clock edge
  always_comb begin
    start = state_q == IDLE && le_fall;
    commit = state_q == SHIFT && le_rise;
    shift_en = state_q == SHIFT && clk_rise && !le_rise;
    good = bit_cnt_q == 6'(WORD_WIDTH);
    full = count == (FIFO_AW + 1)'(DEPTH);
    pop = readStrobe && dataValid;
    push = commit && good && (!full || pop);
  end
  // Shift register, bit counter, FIFO pointers and sticky flag next values
  always_comb begin
    shreg_d = start ? '0 : shift_en ? {shreg_q[WORD_WIDTH-2:0], sdi} : shreg_q;
    bit_cnt_d = start ? '0 : (shift_en && bit_cnt_q != 6'd63) ? bit_cnt_q + 6'd1 : bit_cnt_q;
    last_cnt_d = commit ? bit_cnt_q : last_cnt_q;
    wptr_d = wptr_q + (FIFO_AW + 1)'(push);
    rptr_d = rptr_q + (FIFO_AW + 1)'(pop);
    ovf_d = (ovf_q && !clearStatus) || (commit && good && full && !pop);
    len_d = (len_q && !clearStatus) || (commit && !good);
  end
  // Datapath and status registers
  always_ff @(posedge sysClk or negedge sysReset_n)
    if (!sysReset_n) begin
      shreg_q <= '0;
      bit_cnt_q <= '0;
      last_cnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q <= 1'b0;
      len_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_cnt_q <= last_cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q <= ovf_d;
      len_q <= len_d;
    end
  // FIFO storage; a full-FIFO push with pop reuses the slot being vacated
  always_ff @(posedge sysClk)
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= shreg_q;
  assign dataValid = count != '0;
  assign dataOut = dataValid ? mem_q[rptr_q[FIFO_AW-1:0]] : '0;
  assign fifoCount = count;
  assign lastBitCount = last_cnt_q;
  assign overflow = ovf_q;
  assign lengthError = len_q;
endmodule

// File: tb/tb_afe_spi_capture.sv
// tb_afe_spi_capture: table-driven and scoreboard checks of the AFE SPI capture block
module tb_afe_spi_capture;
  logic sysClk = 1'b0;
  logic sysReset_n = 1'b0;
  logic spiClk = 1'b0;
  logic spiSdi = 1'b0;
  logic spiLe = 1'b1;
  logic readStrobe = 1'b0;
  logic clearStatus = 1'b0;
  logic dataValid;
  logic [23:0] dataOut;
  logic [3:0] fifoCount;
  logic [5:0] lastBitCount;
  logic overflow, lengthError;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] sb[$];
  typedef struct {
    logic [63:0] data;
    int nbits;
    logic [5:0] exp_last;
    logic exp_len;
    int exp_cnt;
    logic [63:0] exp_head;
  } vec_t;
  vec_t vecs[3];
  afe_spi_capture #(.WORD_WIDTH(24), .FIFO_AW(3)) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .spiClk(spiClk), .spiSdi(spiSdi),
    .spiLe(spiLe), .readStrobe(readStrobe), .clearStatus(clearStatus),
    .dataValid(dataValid), .dataOut(dataOut), .fifoCount(fifoCount),
    .lastBitCount(lastBitCount), .overflow(overflow), .lengthError(lengthError)
  );
  always #5 sysClk = ~sysClk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge sysClk);
  endtask
  task automatic send_bits(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spiSdi = d[i];
      cyc(5);
      spiClk = 1'b1;
      cyc(5);
      spiClk = 1'b0;
    end
  endtask
  task automatic le_low();
    spiLe = 1'b0;
    cyc(6);
  endtask
  task automatic le_high(input bit pop_at_commit);
    spiLe = 1'b1;
    if (pop_at_commit) begin
      @(posedge sysClk);
      @(posedge sysClk);
      @(negedge sysClk);
      chk("head_at_commit", dataOut, sb[0]);
      void'(sb.pop_front());
      readStrobe = 1'b1;
      @(negedge sysClk);
      readStrobe = 1'b0;
    end
    cyc(6);
  endtask
  task automatic frame(input logic [63:0] d, input int n, input bit pop_at_commit);
    le_low();
    send_bits(d, n);
    cyc(5);
    le_high(pop_at_commit);
  endtask
  task automatic read_check(input string nm);
    logic [63:0] e;
    e = sb.pop_front();
    chk({nm, "_valid"}, dataValid, 1'b1);
    chk(nm, dataOut, e);
    readStrobe = 1'b1;
    @(negedge sysClk);
    readStrobe = 1'b0;
    @(negedge sysClk);
  endtask
  task automatic clear_status();
    clearStatus = 1'b1;
    @(negedge sysClk);
    clearStatus = 1'b0;
    @(negedge sysClk);
  endtask
  initial begin
    vecs[0] = '{64'hA5C3F0, 24, 6'd24, 1'b0, 1, 64'hA5C3F0};
    vecs[1] = '{64'h7F00FF, 23, 6'd23, 1'b1, 1, 64'hA5C3F0};
    vecs[2] = '{64'h1ABCDEF, 25, 6'd25, 1'b1, 1, 64'hA5C3F0};
    cyc(3);
    chk("rst_valid", dataValid, 1'b0);
    chk("rst_data", dataOut, 64'h0);
    chk("rst_count", fifoCount, 64'h0);
    chk("rst_last", lastBitCount, 64'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_len", lengthError, 1'b0);
    sysReset_n = 1'b1;
    cyc(6);
    for (int v = 0; v < 3; v++) begin
      if (vecs[v].nbits == 24) sb.push_back(vecs[v].data);
      frame(vecs[v].data, vecs[v].nbits, 1'b0);
      chk("vec_last", lastBitCount, vecs[v].exp_last);
      chk("vec_len", lengthError, vecs[v].exp_len);
      chk("vec_count", fifoCount, vecs[v].exp_cnt);
      chk("vec_head", dataOut, vecs[v].exp_head);
      chk("vec_ovf", overflow, 1'b0);
    end
    clear_status();
    chk("len_cleared", lengthError, 1'b0);
    read_check("read_a5");
    chk("empty_after_read", dataValid, 1'b0);
    readStrobe = 1'b1;
    @(negedge sysClk);
    readStrobe = 1'b0;
    chk("empty_pop_count", fifoCount, 64'h0);
    for (int k = 1; k <= 9; k++) begin
      if (sb.size() < 8) sb.push_back(64'(k));
      frame(64'(k), 24, 1'b0);
    end
    chk("fill_count", fifoCount, 64'd8);
    chk("fill_ovf", overflow, 1'b1);
    chk("fill_len", lengthError, 1'b0);
    for (int k = 1; k <= 8; k++) read_check("fill_read");
    chk("fill_empty", fifoCount, 64'h0);
    clear_status();
    chk("ovf_cleared", overflow, 1'b0);
    for (int k = 0; k < 8; k++) begin
      sb.push_back(64'h100 + 64'(k));
      frame(64'h100 + 64'(k), 24, 1'b0);
    end
    chk("full_count", fifoCount, 64'd8);
    sb.push_back(64'h123456);
    frame(64'h123456, 24, 1'b1);
    chk("pushpop_count", fifoCount, 64'd8);
    chk("pushpop_ovf", overflow, 1'b0);
    for (int k = 0; k < 8; k++) read_check("pushpop_read");
    chk("pushpop_sb_empty", 64'(sb.size()), 64'h0);
    le_low();
    send_bits(64'h5A5A5A, 24);
    cyc(5);
    spiSdi = 1'b1;
    spiClk = 1'b1;
    sb.push_back(64'h5A5A5A);
    le_high(1'b0);
    spiClk = 1'b0;
    cyc(6);
    chk("coinc_last", lastBitCount, 64'd24);
    chk("coinc_len", lengthError, 1'b0);
    read_check("coinc_word");
    le_low();
    send_bits(64'h3FF, 10);
    sysReset_n = 1'b0;
    cyc(3);
    sysReset_n = 1'b1;
    cyc(4);
    send_bits(64'h3FFF, 14);
    cyc(5);
    le_high(1'b0);
    chk("midrst_valid", dataValid, 1'b0);
    chk("midrst_len", lengthError, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_last", lastBitCount, 64'h0);
    sb.push_back(64'h3C3C3C);
    frame(64'h3C3C3C, 24, 1'b0);
    chk("post_rst_last", lastBitCount, 64'd24);
    chk("post_rst_count", fifoCount, 64'd1);
    read_check("post_rst_word");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/afe_spi_capture.md
Name: afe_spi_capture

Overview:
- Receive-side counterpart of the AFE SPI write interface (AFE_SPI_CLK/SDI/LE).
- Oversamples one AFE SPI lane in the sysClk domain and reassembles each LE-framed word.
- Queues completed words in a small show-ahead FIFO for readback by the CPU register block.
- Used for loopback verification of AFE programming and by the bench as the AFE responder model; one instance per lane.

Parameters:
- WORD_WIDTH, 24, bits per AFE SPI word, MSB first; legal range 2..62.
- FIFO_AW, 3, FIFO address width; depth is 2**FIFO_AW words.

Ports:
- sysClk  in  1  system clock; all logic runs on it.
- sysReset_n  in  1  asynchronous, active-low reset.
- spiClk  in  1  AFE SPI clock; asynchronous to sysClk.
- spiSdi  in  1  AFE SPI serial data; asynchronous to sysClk.
- spiLe  in  1  AFE SPI latch enable; low while shifting, rising edge commits the word; asynchronous to sysClk.
- readStrobe  in  1  pops the FIFO head; ignored when dataValid=0.
- clearStatus  in  1  clears the sticky status flags.
- dataValid  out  1  FIFO not empty.
- dataOut  out  WORD_WIDTH  FIFO head word (show-ahead).
- fifoCount  out  FIFO_AW+1  number of words held.
- lastBitCount  out  6  bit count of the most recently completed frame.
- overflow  out  1  sticky: a good word was dropped because the FIFO was full.
- lengthError  out  1  sticky: a frame's bit count was not WORD_WIDTH.

Behaviour:
- Reset: all outputs are 0 (dataOut=0, fifoCount=0); synchronizers, shift register, bit counter and FIFO pointers are cleared; the FSM enters IDLE.
- Input sampling:
  - spiClk, spiSdi and spiLe each pass through a 2-flop synchronizer, then one history flop.
  - Edges are detected as sync & ~hist.
  - An input edge is acted on 3 sysClk cycles after it occurs; SDI is taken from the same pipeline stage as the clock edge.
  - Requirement: spiClk high and low times ≥ 3 sysClk periods; SDI stable ≥ 2 sysClk periods around the spiClk rise.
- FSM has two states:
  - IDLE (synced LE high): spiClk edges are ignored. Synced LE falling edge → clear shift register and bit counter, go to SHIFT.
  - SHIFT: each synced spiClk rising edge does shreg <= {shreg[W-2:0], sdi}; bitCnt increments and saturates at 63. Synced LE rising edge → commit, go to IDLE.
- Commit (one cycle), in order:
  - lastBitCount <= bitCnt.
  - If bitCnt == WORD_WIDTH: push shreg[WORD_WIDTH-1:0] into the FIFO. If the FIFO is full and there is no concurrent pop, drop the word and set overflow.
  - Otherwise (including 0 bits and saturation): set lengthError and push nothing.
- Only the last WORD_WIDTH bits are retained when more are shifted in; these frames are still flagged as length errors.
- Simultaneous spiClk rise and LE rise in the same detect cycle: the LE rise wins and the bit is not shifted.
- FIFO:
  - dataOut reflects the head combinationally from the storage array, with no extra latency.
  - A push becomes visible on dataValid/dataOut the cycle after the commit.
  - readStrobe with dataValid=1 advances the head next cycle; readStrobe when empty has no effect.
  - Push and pop in the same cycle while full: the pop frees a slot, the push succeeds, no overflow.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
  - fifoCount is exact at all times.
- Sticky flags: clearStatus clears overflow and lengthError. A set event in the same cycle as clearStatus wins (flag = 1).
- Reset mid-frame (LE low when reset releases): the synced LE history comes up low, so no falling edge is seen and the FSM stays IDLE. Bits are ignored until the next LE rise; that rise commits nothing and flags nothing.

Test Plan:
- WORD_WIDTH=24, frame 0xA5C3F0 sent MSB first, spiClk half-period 5 sysClk → dataValid=1, dataOut=0xA5C3F0, lastBitCount=24, fifoCount=1, no flags.
- 23-bit frame, then 25-bit frame → no FIFO push for either; lengthError=1; lastBitCount=23 then 25. clearStatus → lengthError=0.
- 9 good frames 0x000001..0x000009 with no reads, FIFO_AW=3 → fifoCount=8, overflow=1; reads return 0x000001..0x000008 in order.
- FIFO full with readStrobe asserted in the exact commit cycle of frame 0x123456 → fifoCount stays 8, overflow=0, 0x123456 is the last word read.
- spiClk rise coincident with the LE rise after 24 bits → that edge is not shifted, word committed with 24 bits. Separately, reset asserted after 10 bits and released with LE low → no push and no flags at the LE rise; the next full frame is captured correctly.
